data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single byte-addressed, big-endian 16-bit data memory between two requesters.
//  The requesters are the CPU load/store port (CPU) and a debug/loader port (DBG).
//  Sits between the datapath ALU-address/ReadRT path and the data memory.
//  Serialises accesses through a 3-state FSM with request/ack handshake, round-robin or fixed priority,
//  registered read data and an out-of-range error response.
// PARAMETERS
//  MEM_BYTES      128  data memory size in bytes; legal access iff addr+1 <= MEM_BYTES-1
//  FIXED_PRIO     0    0 = round-robin between CPU/DBG; 1 = CPU always wins ties
// PORTS
//  Clock      in   1   single clock, all state updates on posedge
//  Reset_n    in   1   asynchronous, active-low reset
//  cpu_req    in   1   CPU access request, held until cpu_ack
//  cpu_we     in   1   1 = store word, 0 = load word
//  cpu_addr   in   16  byte address (odd allowed; bytes addr, addr+1)
//  cpu_wdata  in   16  store data ([15:8] -> addr, [7:0] -> addr+1)
//  cpu_ack    out  1   one-cycle completion pulse
//  cpu_rdata  out  16  load data, valid while cpu_ack=1, held until next CPU ack
//  cpu_err    out  1   with cpu_ack: address out of range, no memory effect
//  cpu_stall  out  1   cpu_req & ~cpu_ack (combinational), freezes PC/regfile write
//  dbg_req/dbg_we/dbg_addr/dbg_wdata/dbg_ack/dbg_rdata/dbg_err  same as cpu_* for DBG
//  mem_addr   out  16  memory byte address
//  mem_wdata  out  16  memory write data
//  mem_we     out  1   memory write strobe; memory commits at posedge while mem_we=1
//  mem_re     out  1   memory read qualifier
//  mem_rdata  in   16  memory combinational read data {m[addr], m[addr+1]}
// BEHAVIOUR
//  Reset (async, Reset_n=0): state=IDLE; every output 0; last_grant=DBG (CPU wins first tie).
//  Reset takes effect immediately: mem_we drops at once, and a write not yet committed at a posedge is lost.
//  FSM states:
//   IDLE:   at posedge, if any req is high, pick a winner; latch its we/addr/wdata and err.
//           err = (addr > MEM_BYTES-2).
//           Then go to ACCESS; with no req, stay in IDLE.
//   ACCESS: mem_addr/mem_wdata = latched values.
//           mem_we = lat_we & ~err; mem_re = ~lat_we & ~err.
//           At posedge: the memory write commits; rdata_reg <= err ? 0 : mem_rdata (loads only). Go to RESP.
//   RESP:   the winner's ack=1 and err=lat_err; its rdata = rdata_reg. Set last_grant=winner. Go to IDLE.
//  Winner selection:
//   only one req high -> that one.
//   both high -> FIXED_PRIO=1: CPU; FIXED_PRIO=0: the requester not equal to last_grant.
//  Latency: req sampled high at edge E (end of IDLE) -> ACCESS in cycle E+1, ack in cycle E+2.
//   Minimum 3 cycles per transaction; back-to-back throughput is 1 access per 3 cycles.
//  Handshake:
//   requester holds req/we/addr/wdata stable until ack.
//   requester must drive req low in the cycle after ack; if req is still high at the IDLE edge, a new transaction starts.
//   Requester inputs changing during ACCESS/RESP are ignored (values are latched).
//  A requester losing arbitration keeps req high; it is granted at the next IDLE (guaranteed in round-robin mode).
//  rdata on a store ack is unchanged from the previous load; rdata of the non-winning port is never modified.
//  mem_addr/mem_wdata hold their last latched values outside ACCESS; mem_we=mem_re=0 outside ACCESS.
//  Error access (addr=MEM_BYTES-1 or higher): full 3-cycle sequence; mem_we=mem_re=0; ack with err=1; rdata=0.
//  Reset asserted mid-ACCESS/RESP: no ack is issued, and a pending requester must re-request after reset.
// TESTING
//  1. Reset, CPU load addr 0x0004 with mem bytes {0x12,0x34}
//     -> cpu_ack in cycle 3 after req, cpu_rdata=0x1234, cpu_err=0.
//  2. CPU store 0xBEEF to 0x0010 -> mem_we=1 for exactly one cycle; then DBG load 0x0010 -> dbg_rdata=0xBEEF.
//  3. cpu_req and dbg_req both high continuously, FIXED_PRIO=0
//     -> ack order CPU, DBG, CPU, DBG, each 3 cycles apart; with FIXED_PRIO=1 -> CPU only (DBG starved).
//  4. DBG store to 0x007F (MEM_BYTES=128)
//     -> dbg_ack with dbg_err=1, mem_we never asserted, memory unchanged.
//  5. Reset_n pulsed low during ACCESS of a CPU store
//     -> mem_we drops immediately, no cpu_ack, all outputs 0, memory unchanged.
//  6. cpu_req held one cycle past ack -> second transaction starts; cpu_stall tracks req&~ack each cycle.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one big-endian 16-bit, byte-addressed data memory
// between the CPU load/store port and the debug/loader port.
// Each access runs IDLE -> ACCESS -> RESP, so one access completes every
// three cycles. Out-of-range accesses still take all three cycles, never
// touch memory, and complete with err=1.
//
// Handshake (both ports): the requester raises req with we/addr/wdata and
// holds them stable until the one-cycle ack pulse. It drops req in the cycle
// after ack; a req still high at the next IDLE edge starts a new access.
// Inputs are latched at the IDLE edge, so later changes are ignored.
module data_mem_arbiter #(
  parameter int MEM_BYTES  = 128,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // CPU load/store port
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [15:0] cpu_wdata_i,
  output logic        cpu_ack_o,
  output logic [15:0] cpu_rdata_o,
  output logic        cpu_err_o,
  output logic        cpu_stall_o,
  // debug/loader port
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [15:0] dbg_addr_i,
  input  logic [15:0] dbg_wdata_i,
  output logic        dbg_ack_o,
  output logic [15:0] dbg_rdata_o,
  output logic        dbg_err_o,
  // data memory side
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [15:0] mem_rdata_i,
  // FSM state for observation
  output logic [1:0]  state_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic SEL_CPU = 1'b0;
  localparam logic SEL_DBG = 1'b1;

  // Highest legal start address: the word touches addr and addr+1.
  localparam logic [15:0] LAST_OK_ADDR = 16'(MEM_BYTES - 2);

  logic [1:0]  state_q, state_d;
  logic        sel_q, sel_d;
  logic        lat_we_q, lat_we_d;
  logic [15:0] lat_addr_q, lat_addr_d;
  logic [15:0] lat_wdata_q, lat_wdata_d;
  logic        lat_err_q, lat_err_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] dbg_rdata_q, dbg_rdata_d;

  logic        grant_dbg;
  logic [15:0] req_addr;
  logic        in_access;
  logic        in_resp;

  // Arbitration: a lone requester wins; on a tie CPU wins in fixed mode,
  // otherwise whoever was not granted last.
  always_comb begin
    grant_dbg = dbg_req_i &
                (~cpu_req_i | (~FIXED_PRIO & (last_grant_q == SEL_CPU)));
    req_addr  = grant_dbg ? dbg_addr_i : cpu_addr_i;
  end

  // Next-state, request latching and read-data capture.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    lat_we_d     = lat_we_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    lat_err_d    = lat_err_q;
    last_grant_d = last_grant_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req_i | dbg_req_i) begin
          sel_d       = grant_dbg;
          lat_we_d    = grant_dbg ? dbg_we_i : cpu_we_i;
          lat_addr_d  = req_addr;
          lat_wdata_d = grant_dbg ? dbg_wdata_i : cpu_wdata_i;
          lat_err_d   = (req_addr > LAST_OK_ADDR);
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Only loads update the winner's read data; stores leave it alone.
        if (!lat_we_q) begin
          if (sel_q == SEL_CPU) begin
            cpu_rdata_d = lat_err_q ? 16'h0000 : mem_rdata_i;
          end else begin
            dbg_rdata_d = lat_err_q ? 16'h0000 : mem_rdata_i;
          end
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        last_grant_d = sel_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset clears every output-driving register at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      sel_q        <= SEL_CPU;
      lat_we_q     <= 1'b0;
      lat_addr_q   <= 16'h0000;
      lat_wdata_q  <= 16'h0000;
      lat_err_q    <= 1'b0;
      last_grant_q <= SEL_DBG;
      cpu_rdata_q  <= 16'h0000;
      dbg_rdata_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      lat_we_q     <= lat_we_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_err_q    <= lat_err_d;
      last_grant_q <= last_grant_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Output decode; strobes exist only in ACCESS, acks only in RESP.
  always_comb begin
    in_access   = (state_q == S_ACCESS);
    in_resp     = (state_q == S_RESP);
    mem_addr_o  = lat_addr_q;
    mem_wdata_o = lat_wdata_q;
    mem_we_o    = in_access & lat_we_q & ~lat_err_q;
    mem_re_o    = in_access & ~lat_we_q & ~lat_err_q;
    cpu_ack_o   = in_resp & (sel_q == SEL_CPU);
    dbg_ack_o   = in_resp & (sel_q == SEL_DBG);
    cpu_err_o   = cpu_ack_o & lat_err_q;
    dbg_err_o   = dbg_ack_o & lat_err_q;
    cpu_rdata_o = cpu_rdata_q;
    dbg_rdata_o = dbg_rdata_q;
    // Stall is forced low during reset so all outputs read zero.
    cpu_stall_o = rst_n_i & cpu_req_i & ~cpu_ack_o;
    state_o     = state_q;
  end

endmodule
